vga_fb_ctrl: RTL and testbench

Parametrised VGA controller with an on-chip framebuffer; generational successor to the fixed 1280x1024 top.
- Generic timing generator (every H/V interval and sync polarity is a parameter).
- Downscaled framebuffer of COLOR_BITS-wide palette indices, written by the host one pixel per cycle and scanned out through a palette.
- Status outputs for the board LEDs.
- Sits between the host/pixel writer and the VGA connector, in the pixel clock domain.

---
 rtl/vga_fb_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_vga_fb_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_ctrl
// Description : Parametrised VGA timing generator with a downscaled on-chip
//               framebuffer, palette scan-out and LED status counters.
//               Optional macro VGA_FB_PALETTE_WR_EN adds a writable palette.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_ctrl #(
    parameter int   HD         = 1280,
    parameter int   HFP        = 48,
    parameter int   HSW        = 112,
    parameter int   HBP        = 248,
    parameter int   VD         = 1024,
    parameter int   VFP        = 1,
    parameter int   VSW        = 3,
    parameter int   VBP        = 38,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   COORD_BITS = 11,
    parameter int   SCALE_LOG2 = 3,
    parameter int   COLOR_BITS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef VGA_FB_PALETTE_WR_EN
    input  logic                  pal_we_i,
    input  logic [COLOR_BITS-1:0] pal_idx_i,
    input  logic [11:0]           pal_rgb_i,
`endif
    input  logic [COORD_BITS-1:0] addr_x_i,
    input  logic [COORD_BITS-1:0] addr_y_i,
    input  logic [COLOR_BITS-1:0] color_i,
    input  logic                  we_i,
    output logic                  wr_ready_o,
    output logic                  VGA_HS_o,
    output logic                  VGA_VS_o,
    output logic [11:0]           RGB_o,
    output logic                  frame_start_o,
    output logic [11:0]           LED_o
);

    localparam int c_ht       = HD + HFP + HSW + HBP;
    localparam int c_vt       = VD + VFP + VSW + VBP;
    localparam int c_fb_w     = HD >> SCALE_LOG2;
    localparam int c_fb_depth = (HD >> SCALE_LOG2) * (VD >> SCALE_LOG2);
    localparam int c_aw       = (c_fb_depth > 1) ? $clog2(c_fb_depth) : 1;

    localparam logic [COORD_BITS-1:0] c_one    = COORD_BITS'(1);
    localparam logic [COORD_BITS-1:0] c_hd     = COORD_BITS'(HD);
    localparam logic [COORD_BITS-1:0] c_hs_beg = COORD_BITS'(HD + HFP);
    localparam logic [COORD_BITS-1:0] c_hs_end = COORD_BITS'(HD + HFP + HSW);
    localparam logic [COORD_BITS-1:0] c_h_last = COORD_BITS'(c_ht - 1);
    localparam logic [COORD_BITS-1:0] c_vd     = COORD_BITS'(VD);
    localparam logic [COORD_BITS-1:0] c_vs_beg = COORD_BITS'(VD + VFP);
    localparam logic [COORD_BITS-1:0] c_vs_end = COORD_BITS'(VD + VFP + VSW);
    localparam logic [COORD_BITS-1:0] c_v_last = COORD_BITS'(c_vt - 1);
    localparam logic [c_aw-1:0]       c_row_w  = c_aw'(c_fb_w);

    logic [COORD_BITS-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic                  wr_ready_q;
    logic                  vis1_q, hs1_q, vs1_q, fs1_q;
    logic [11:0]           rgb_q;
    logic                  hs_q, vs_q, fs_q;
    logic [7:0]            frame_cnt_q;
    logic [3:0]            drop_cnt_q;
    logic [COLOR_BITS-1:0] pix_idx_q;
    logic [COLOR_BITS-1:0] fb_mem_q [c_fb_depth];

    logic                  w_visible, w_hs_raw, w_vs_raw, w_frame_pt;
    logic [c_aw-1:0]       w_rd_addr, w_wr_addr;
    logic                  w_wr_acc, w_wr_in_range;
    logic [11:0]           w_pal_rgb;

    function automatic logic [11:0] pal_default(input logic [COLOR_BITS-1:0] idx);
        logic [3:0]  c;
        logic [11:0] rgb;
        c = 4'(idx);
        if (COLOR_BITS == 2) begin
            case (c)
                4'd0:    rgb = 12'h000;
                4'd1:    rgb = 12'hF00;
                4'd2:    rgb = 12'h0F0;
                default: rgb = 12'hFFF;
            endcase
        end else begin
            rgb = {c, c, c};
        end
        return rgb;
    endfunction

    always_comb begin
        h_cnt_d = h_cnt_q + c_one;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == c_h_last) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + c_one;
        end
    end

    assign w_visible  = (h_cnt_q < c_hd) && (v_cnt_q < c_vd);
    assign w_hs_raw   = (h_cnt_q >= c_hs_beg) && (h_cnt_q < c_hs_end);
    assign w_vs_raw   = (v_cnt_q >= c_vs_beg) && (v_cnt_q < c_vs_end);
    assign w_frame_pt = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Blanking reads are parked on cell 0 so the index never leaves the array.
    assign w_rd_addr = w_visible
                     ? c_aw'(v_cnt_q >> SCALE_LOG2) * c_row_w + c_aw'(h_cnt_q >> SCALE_LOG2)
                     : '0;

    assign w_wr_acc      = we_i & wr_ready_q;
    assign w_wr_in_range = (addr_x_i < c_hd) && (addr_y_i < c_vd);
    assign w_wr_addr     = c_aw'(addr_y_i >> SCALE_LOG2) * c_row_w + c_aw'(addr_x_i >> SCALE_LOG2);

    // Framebuffer is never reset; the registered read returns old data on a same-address write.
    always_ff @(posedge clk_i) begin
        if (w_wr_acc && w_wr_in_range) begin
            fb_mem_q[w_wr_addr] <= color_i;
        end
        pix_idx_q <= fb_mem_q[w_rd_addr];
    end

`ifdef VGA_FB_PALETTE_WR_EN
    logic [11:0] pal_q [2**COLOR_BITS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2**COLOR_BITS; i++) begin
                pal_q[i] <= pal_default(COLOR_BITS'(i));
            end
        end else if (pal_we_i) begin
            pal_q[pal_idx_i] <= pal_rgb_i;
        end
    end

    assign w_pal_rgb = pal_q[pix_idx_q];
`else
    assign w_pal_rgb = pal_default(pix_idx_q);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            wr_ready_q  <= 1'b0;
            vis1_q      <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            fs1_q       <= 1'b0;
            rgb_q       <= '0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            fs_q        <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            wr_ready_q <= 1'b1;
            vis1_q     <= w_visible;
            hs1_q      <= w_hs_raw;
            vs1_q      <= w_vs_raw;
            fs1_q      <= w_frame_pt;
            rgb_q      <= vis1_q ? w_pal_rgb : 12'h000;
            hs_q       <= hs1_q ? HS_POL : ~HS_POL;
            vs_q       <= vs1_q ? VS_POL : ~VS_POL;
            fs_q       <= fs1_q;
            if (w_frame_pt) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            if (w_wr_acc && !w_wr_in_range && (drop_cnt_q != 4'hF)) begin
                drop_cnt_q <= drop_cnt_q + 4'd1;
            end
        end
    end

    assign wr_ready_o    = wr_ready_q;
    assign VGA_HS_o      = hs_q;
    assign VGA_VS_o      = vs_q;
    assign RGB_o         = rgb_q;
    assign frame_start_o = fs_q;
    assign LED_o         = {frame_cnt_q, drop_cnt_q};

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_ctrl
// Description : Scoreboard bench for vga_fb_ctrl on a reduced 48x24 raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_ctrl;

    localparam int HD  = 32;
    localparam int HFP = 4;
    localparam int HSW = 6;
    localparam int HBP = 6;
    localparam int VD  = 16;
    localparam int VFP = 2;
    localparam int VSW = 3;
    localparam int VBP = 3;
    localparam int HT  = HD + HFP + HSW + HBP;   // 48
    localparam int FR  = HT * (VD + VFP + VSW + VBP); // 1152

    localparam int S_RGB = 0, S_HS = 1, S_VS = 2, S_FS = 3, S_LED = 4, S_WRDY = 5;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [10:0] addr_x_i = '0;
    logic [10:0] addr_y_i = '0;
    logic [1:0]  color_i = '0;
    logic        we_i = 1'b0;
    logic        wr_ready_o, VGA_HS_o, VGA_VS_o, frame_start_o;
    logic [11:0] RGB_o, LED_o;
`ifdef VGA_FB_PALETTE_WR_EN
    logic        pal_we_i = 1'b0;
    logic [1:0]  pal_idx_i = '0;
    logic [11:0] pal_rgb_i = '0;
`endif

    vga_fb_ctrl #(
        .HD(HD), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VD(VD), .VFP(VFP), .VSW(VSW), .VBP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b1),
        .COORD_BITS(11), .SCALE_LOG2(3), .COLOR_BITS(2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
`ifdef VGA_FB_PALETTE_WR_EN
        .pal_we_i(pal_we_i),
        .pal_idx_i(pal_idx_i),
        .pal_rgb_i(pal_rgb_i),
`endif
        .addr_x_i(addr_x_i),
        .addr_y_i(addr_y_i),
        .color_i(color_i),
        .we_i(we_i),
        .wr_ready_o(wr_ready_o),
        .VGA_HS_o(VGA_HS_o),
        .VGA_VS_o(VGA_VS_o),
        .RGB_o(RGB_o),
        .frame_start_o(frame_start_o),
        .LED_o(LED_o)
    );

    always #5 clk_i = ~clk_i;

    longint abs_cyc = 0;
    always @(posedge clk_i) abs_cyc <= abs_cyc + 1;

    typedef struct {
        longint      t;
        int          sig;
        logic [11:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void expect_at(longint t, int sig, logic [11:0] e);
        exp_t x;
        x.t = t; x.sig = sig; x.exp = e;
        sb.push_back(x);
    endfunction

    function automatic void expect_pix(longint base, int x, int y, logic [11:0] e);
        expect_at(base + longint'(y * HT + x + 2), S_RGB, e);
    endfunction

    function automatic string sig_name(int s);
        case (s)
            S_RGB:   return "RGB_o";
            S_HS:    return "VGA_HS_o";
            S_VS:    return "VGA_VS_o";
            S_FS:    return "frame_start_o";
            S_LED:   return "LED_o";
            default: return "wr_ready_o";
        endcase
    endfunction

    // Monitor: retires every expectation due in the current cycle.
    always @(negedge clk_i) begin
        logic [11:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].t == abs_cyc) begin
                case (sb[i].sig)
                    S_RGB:   act = RGB_o;
                    S_HS:    act = {11'd0, VGA_HS_o};
                    S_VS:    act = {11'd0, VGA_VS_o};
                    S_FS:    act = {11'd0, frame_start_o};
                    S_LED:   act = LED_o;
                    default: act = {11'd0, wr_ready_o};
                endcase
                n_vec++;
                if (act !== sb[i].exp) begin
                    n_bad++;
                    $display("FAIL %s @cycle %0d: got %h, expected %h",
                             sig_name(sb[i].sig), sb[i].t, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic wait_until(longint t);
        while (abs_cyc < t) @(negedge clk_i);
    endtask

    task automatic wr(int x, int y, int c);
        addr_x_i = 11'(x);
        addr_y_i = 11'(y);
        color_i  = 2'(c);
        we_i     = 1'b1;
        @(negedge clk_i);
        we_i     = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, pending expectations %0d", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint r, f, r1;
        @(negedge clk_i);
        wait_until(2);
        expect_at(4, S_HS, 12'h001);
        expect_at(4, S_VS, 12'h000);
        expect_at(4, S_RGB, 12'h000);
        expect_at(4, S_FS, 12'h000);
        expect_at(4, S_LED, 12'h000);
        expect_at(4, S_WRDY, 12'h000);
        wait_until(5);
        rst_i = 1'b0;
        r = abs_cyc;
        f = r + FR;

        // Timing of the first frame after release
        expect_at(r + 1, S_WRDY, 12'h001);
        expect_at(r + 37, S_HS, 12'h001);
        expect_at(r + 38, S_HS, 12'h000);
        expect_at(r + 43, S_HS, 12'h000);
        expect_at(r + 44, S_HS, 12'h001);
        expect_at(r + 38 + HT, S_HS, 12'h000);
        expect_at(r + 865, S_VS, 12'h000);
        expect_at(r + 866, S_VS, 12'h001);
        expect_at(r + 1009, S_VS, 12'h001);
        expect_at(r + 1010, S_VS, 12'h000);
        expect_at(r + 1, S_FS, 12'h000);
        expect_at(r + 2, S_FS, 12'h001);
        expect_at(r + 3, S_FS, 12'h000);
        expect_at(f + 2, S_FS, 12'h001);
        expect_at(r + 1, S_LED, 12'h010);
        expect_at(r + 201, S_LED, 12'h011);
        expect_at(r + 202, S_LED, 12'h012);
        expect_at(r + 214, S_LED, 12'h01E);
        expect_at(r + 230, S_LED, 12'h01F);
        expect_at(f, S_LED, 12'h01F);
        expect_at(f + 1, S_LED, 12'h02F);

        // Frame 1 pixels: cell0=3, cell1=1, cell2=0, cell4=2, cell7=3
        expect_pix(r, 7, 0, 12'hFFF);
        expect_pix(r, 8, 0, 12'hF00);
        expect_pix(r, 15, 0, 12'hF00);
        expect_pix(r, 16, 0, 12'h000);
        expect_pix(r, 7, 1, 12'hFFF);
        expect_pix(r, 8, 7, 12'hF00);
        expect_pix(r, 40, 0, 12'h000);
        expect_pix(r, 0, 8, 12'h0F0);
        expect_pix(r, 31, 15, 12'hFFF);
        expect_pix(r, 0, 16, 12'h000);

        // Frame 2 pixels, including writes that race the scan-out
        expect_pix(f, 0, 0, 12'hFFF);
        expect_pix(f, 8, 0, 12'h0F0);
        expect_pix(f, 15, 0, 12'h0F0);
        expect_pix(f, 16, 0, 12'h000);
        expect_pix(f, 17, 0, 12'hF00);
        expect_pix(f, 0, 8, 12'h0F0);
        expect_at(f + 518, S_HS, 12'h000);
        expect_at(f + 519, S_HS, 12'h001);
        expect_at(f + 519, S_VS, 12'h000);
        expect_at(f + 519, S_LED, 12'h000);
        expect_at(f + 519, S_WRDY, 12'h000);

        wait_until(r + 1);
        wr(8, 0, 1);
        wr(0, 0, 3);
        wr(16, 0, 0);
        wr(0, 8, 2);
        wr(24, 8, 3);

        wait_until(r + 200);
        wr(32, 0, 1);
        wr(0, 16, 1);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) wr(40 + i, 0, 1);
            else            wr(5, 16 + i, 2);
        end

        wait_until(f + 7);
        wr(8, 0, 2);
        wait_until(f + 16);
        wr(16, 0, 1);

        // Reset in the middle of line 10 while HSYNC is asserted
        wait_until(f + 518);
        rst_i = 1'b1;
        wait_until(f + 522);
        rst_i = 1'b0;
        r1 = abs_cyc;
        expect_at(r1 + 1, S_WRDY, 12'h001);
        expect_at(r1 + 1, S_LED, 12'h010);
        expect_at(r1 + 2, S_FS, 12'h001);
        expect_at(r1 + 37, S_HS, 12'h001);
        expect_at(r1 + 38, S_HS, 12'h000);
        expect_pix(r1, 7, 0, 12'hFFF);
        expect_pix(r1, 8, 0, 12'h0F0);
        expect_pix(r1, 16, 0, 12'hF00);
        expect_pix(r1, 0, 8, 12'h0F0);
        expect_pix(r1, 31, 15, 12'hFFF);
        expect_pix(r1, 0, 16, 12'h000);

        wait_until(r1 + 16 * HT + 10);
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk_i);
        if (sb.size() > 0) begin
            n_bad += sb.size();
            $display("FAIL scoreboard: %0d expectations never retired", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
